// File: rtl/store_buffer_if.sv
// Store buffer bus: the pipeline store/load ports, the drain control and
// the data-memory read/write ports, bundled so they travel as one port.
interface store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // pipeline store side
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;

  // pipeline load side
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  // retirement control
  logic              drain_en;

  // data memory side
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  // status
  logic [CNT_W-1:0]  count;
  logic              empty;

  // pipeline + memory environment driving the buffer
  modport master (
    output st_valid, st_addr, st_data, ld_addr, drain_en, mem_rdata,
    input  st_ready, ld_data, mem_raddr, mem_waddr, mem_wdata, mem_we, count, empty
  );

  // the store buffer itself
  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, drain_en, mem_rdata,
    output st_ready, ld_data, mem_raddr, mem_waddr, mem_wdata, mem_we, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer between the memory stage and data memory. Stores are queued
// in a circular FIFO and retired in program order, one per cycle, while
// drain_en is high. Loads check every occupied entry and take the youngest
// word-matching store, falling back to the memory read data.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  // Entry storage: read combinationally by both the drain port and the
  // forwarding comparators, so it stays in registers rather than RAM.
  logic [ADDR_W-1:0] entryAddr [DEPTH];
  logic [DATA_W-1:0] entryData [DEPTH];

  logic [PTR_W-1:0] headReg;
  logic [PTR_W-1:0] tailReg;
  logic [PTR_W:0]   countReg;

  logic isEmpty;
  logic isFull;
  logic doEnq;
  logic doDeq;

  // Occupancy flags come from the registered count only, so st_ready never
  // depends on this cycle's drain (no bypass while full).
  assign isEmpty = (countReg == '0);
  assign isFull  = (countReg == FULL_COUNT);
  assign doEnq   = bus.st_valid && !isFull;
  assign doDeq   = bus.drain_en && !isEmpty;

  assign bus.st_ready  = !isFull;
  assign bus.empty     = isEmpty;
  assign bus.count     = countReg;

  // Drain port presents the head entry; memory commits on the same edge
  // that advances head. Reset clears count, so mem_we drops immediately.
  assign bus.mem_we    = doDeq;
  assign bus.mem_waddr = entryAddr[headReg];
  assign bus.mem_wdata = entryData[headReg];

  assign bus.mem_raddr = bus.ld_addr;

  // Capture an accepted store into the tail slot (contents need no reset).
  always_ff @(posedge clk) begin
    if (doEnq) begin
      entryAddr[tailReg] <= bus.st_addr;
      entryData[tailReg] <= bus.st_data;
    end
  end

  // Advance pointers and track occupancy; simultaneous enq+deq cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headReg  <= '0;
      tailReg  <= '0;
      countReg <= '0;
    end else begin
      if (doEnq) begin
        tailReg <= tailReg + PTR_W'(1);
      end
      if (doDeq) begin
        headReg <= headReg + PTR_W'(1);
      end
      case ({doEnq, doDeq})
        2'b10:   countReg <= countReg + (PTR_W + 1)'(1);
        2'b01:   countReg <= countReg - (PTR_W + 1)'(1);
        default: countReg <= countReg;
      endcase
    end
  end

  // Forwarding comparators indexed by age: slot gi is the gi-th oldest
  // entry, valid only while gi < count. Byte offset bits are ignored so a
  // match means the same memory word.
  logic [PTR_W-1:0] slotIdx [DEPTH];
  logic [DEPTH-1:0] ageHit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gAge
      assign slotIdx[gi] = headReg + PTR_W'(gi);
      assign ageHit[gi]  = (countReg > (PTR_W + 1)'(gi)) &&
                           (entryAddr[slotIdx[gi]][ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2]);
    end
  endgenerate

  logic [DATA_W-1:0] ldData;

  // Pick the youngest hit: scan oldest to youngest, later hits override.
  // A store being accepted this cycle is not yet in the array, so it never
  // forwards to a same-cycle load.
  always_comb begin
    ldData = bus.mem_rdata;
    for (int k = 0; k < DEPTH; k++) begin
      if (ageHit[k]) begin
        ldData = entryData[slotIdx[k]];
      end
    end
  end

  assign bus.ld_data = ldData;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: per-feature tasks with inline checks, plus a
// negedge scoreboard that models the buffer as a queue of accepted stores
// and checks every memory write against it in order.
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   writes;

  ent_t sbq[$];

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: inputs are stable from posedge+1 to the next posedge, so
  // the negedge view predicts exactly what the coming edge will do.
  logic       expWe;
  logic       expReady;
  logic [2:0] expCount;
  ent_t       expEnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else begin
      expWe    = bus.drain_en && (sbq.size() != 0);
      expReady = (sbq.size() != DEPTH);
      expCount = 3'(sbq.size());
      checks++;
      if (bus.mem_we !== expWe) begin
        errors++;
        $display("FAIL sb_mem_we got %b want %b", bus.mem_we, expWe);
      end
      checks++;
      if (bus.st_ready !== expReady) begin
        errors++;
        $display("FAIL sb_st_ready got %b want %b", bus.st_ready, expReady);
      end
      checks++;
      if (bus.count !== expCount) begin
        errors++;
        $display("FAIL sb_count got %0d want %0d", bus.count, expCount);
      end
      if (expWe) begin
        expEnt = sbq.pop_front();
        checks++;
        if (bus.mem_waddr !== expEnt.a || bus.mem_wdata !== expEnt.d) begin
          errors++;
          $display("FAIL sb_write got %h:%h want %h:%h", bus.mem_waddr, bus.mem_wdata, expEnt.a, expEnt.d);
        end else begin
          $display("write addr=%h data=%h", bus.mem_waddr, bus.mem_wdata);
        end
        writes++;
      end
      if (bus.st_valid && expReady) begin
        sbq.push_back({bus.st_addr, bus.st_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    tick();
    bus.st_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.st_valid = 1'b1;
    bus.st_addr  = 10'h100;
    bus.st_data  = 32'hBAD0BAD0;
    bus.drain_en = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++;
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++;
    if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b want 1", bus.st_ready); end
    checks++;
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
    bus.st_valid = 1'b0;
    bus.drain_en = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_nocapture got %0d want 0", bus.count); end
  endtask

  task automatic test_forwarding();
    bus.drain_en = 1'b0;
    put(10'h010, 32'hDEADBEEF);
    put(10'h014, 32'h12345678);
    bus.ld_addr = 10'h012;
    #1;
    checks++;
    if (bus.ld_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_012 got %h want deadbeef", bus.ld_data); end
    bus.ld_addr = 10'h014;
    #1;
    checks++;
    if (bus.ld_data !== 32'h12345678) begin errors++; $display("FAIL fwd_014 got %h want 12345678", bus.ld_data); end
    bus.ld_addr = 10'h018;
    #1;
    checks++;
    if (bus.ld_data !== 32'h0) begin errors++; $display("FAIL fwd_018 got %h want 0", bus.ld_data); end
    tick();
    // head entry still forwards while it is being written
    bus.drain_en = 1'b1;
    bus.ld_addr  = 10'h010;
    #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.ld_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fwd_draining got we=%b data=%h want we=1 data=deadbeef", bus.mem_we, bus.ld_data);
    end
    repeat (3) tick();
    bus.drain_en = 1'b0;
    checks++;
    if (bus.count !== 3'd0) begin errors++; $display("FAIL fwd_drained got %0d want 0", bus.count); end
  endtask

  task automatic test_youngest();
    bus.drain_en = 1'b0;
    put(10'h020, 32'h1);
    put(10'h022, 32'h2);
    bus.ld_addr = 10'h020;
    #1;
    checks++;
    if (bus.ld_data !== 32'h2) begin errors++; $display("FAIL young_data got %h want 2", bus.ld_data); end
    checks++;
    if (bus.count !== 3'd2) begin errors++; $display("FAIL young_count got %0d want 2", bus.count); end
    // a store being accepted this cycle must not forward yet
    bus.mem_rdata = 32'h55;
    bus.st_valid  = 1'b1;
    bus.st_addr   = 10'h030;
    bus.st_data   = 32'h99;
    bus.ld_addr   = 10'h030;
    #1;
    checks++;
    if (bus.ld_data !== 32'h55) begin errors++; $display("FAIL same_cycle_nofwd got %h want 55", bus.ld_data); end
    tick();
    bus.st_valid = 1'b0;
    #1;
    checks++;
    if (bus.ld_data !== 32'h99) begin errors++; $display("FAIL next_cycle_fwd got %h want 99", bus.ld_data); end
    bus.mem_rdata = 32'h0;
    bus.drain_en  = 1'b1;
    repeat (4) tick();
    bus.drain_en = 1'b0;
    checks++;
    if (bus.count !== 3'd0) begin errors++; $display("FAIL young_drained got %0d want 0", bus.count); end
  endtask

  task automatic test_full();
    int w0;
    w0 = writes;
    bus.drain_en = 1'b0;
    for (int i = 0; i < 4; i++) put(10'(i * 4), 32'(i + 1));
    checks++;
    if (bus.count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", bus.count); end
    checks++;
    if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", bus.st_ready); end
    bus.st_valid = 1'b1;
    bus.st_addr  = 10'h040;
    bus.st_data  = 32'h5;
    tick();
    checks++;
    if (bus.count !== 3'd4) begin errors++; $display("FAIL full_held got %0d want 4", bus.count); end
    bus.drain_en = 1'b1;
    #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 10'h000 || bus.mem_wdata !== 32'h1 || bus.st_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_drain got we=%b a=%h d=%h rdy=%b want we=1 a=000 d=1 rdy=0",
               bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.st_ready);
    end
    tick();
    checks++;
    if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL full_ready_next got %b want 1", bus.st_ready); end
    tick();
    bus.st_valid = 1'b0;
    repeat (6) tick();
    bus.drain_en = 1'b0;
    checks++;
    if (writes - w0 !== 5) begin errors++; $display("FAIL full_writes got %0d want 5", writes - w0); end
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = writes;
    bus.drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.st_valid = 1'b1;
      bus.st_addr  = 10'(10'h100 + i * 4);
      bus.st_data  = 32'(32'hA000 + i);
      tick();
      checks++;
      if (bus.count !== 3'd1) begin errors++; $display("FAIL steady_count[%0d] got %0d want 1", i, bus.count); end
    end
    bus.st_valid = 1'b0;
    tick();
    bus.drain_en = 1'b0;
    checks++;
    if (bus.count !== 3'd0) begin errors++; $display("FAIL steady_empty got %0d want 0", bus.count); end
    checks++;
    if (writes - w0 !== 10) begin errors++; $display("FAIL steady_writes got %0d want 10", writes - w0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    bus.drain_en = 1'b0;
    put(10'h200, 32'hC1);
    put(10'h204, 32'hC2);
    put(10'h208, 32'hC3);
    checks++;
    if (bus.count !== 3'd3) begin errors++; $display("FAIL rmid_count got %0d want 3", bus.count); end
    bus.drain_en = 1'b1;
    #1;
    checks++;
    if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rmid_we_before got %b want 1", bus.mem_we); end
    w0 = writes;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rmid_we_drop got %b want 0", bus.mem_we); end
    checks++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL rmid_cleared got count=%0d empty=%b want 0/1", bus.count, bus.empty);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    bus.drain_en = 1'b0;
    checks++;
    if (writes !== w0) begin errors++; $display("FAIL rmid_nowrite got %0d want %0d", writes - w0, 0); end
    checks++;
    if (bus.count !== 3'd0) begin errors++; $display("FAIL rmid_after got %0d want 0", bus.count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    writes        = 0;
    rst_n         = 1'b1;
    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.ld_addr   = '0;
    bus.drain_en  = 1'b0;
    bus.mem_rdata = '0;
    #1;
    rst_n = 1'b0;
    test_reset();
    test_forwarding();
    test_youngest();
    test_full();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write buffer between the CPU memory stage and the data memory.
- Accepts stores from the pipeline and retires them to the data memory write port in program order, one per cycle, whenever draining is enabled.
- Loads are steered through the block: a load that hits a buffered store gets the youngest buffered data; otherwise it gets the memory read data.

Parameters:
- DEPTH, 4, number of buffer entries; power of 2, minimum 2.
- ADDR_W, 10, byte address width; matches the data memory address ports.
- DATA_W, 32, data word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- st_valid  input  1  pipeline presents a store this cycle.
- st_addr  input  ADDR_W  store byte address.
- st_data  input  DATA_W  store data.
- st_ready  output  1  buffer can accept a store this cycle.
- ld_addr  input  ADDR_W  load byte address.
- ld_data  output  DATA_W  load result, forwarded or from memory.
- drain_en  input  1  permits retiring the head entry this cycle.
- mem_raddr  output  ADDR_W  to data memory read address.
- mem_rdata  input  DATA_W  from data memory (combinational read).
- mem_waddr  output  ADDR_W  to data memory write address.
- mem_wdata  output  DATA_W  to data memory write data.
- mem_we  output  1  to data memory write enable.
- count  output  log2(DEPTH)+1  number of occupied entries.
- empty  output  1  count == 0.

Behaviour:
- Storage: circular FIFO with head pointer, tail pointer and count. Pointers are log2(DEPTH) bits and wrap naturally.
- Each entry holds the full ADDR_W address and DATA_W data. No per-entry valid bits; occupancy is implied by head and count.
- Reset (rst_n low, asynchronous): head = tail = count = 0. Buffered stores are discarded and never written to memory.
- Values during and immediately after reset: st_ready = 1, empty = 1, mem_we = 0.
- Entry contents are don't-care after reset.
- Enqueue: when st_valid && st_ready at a rising edge, write entry[tail] and advance tail.
- st_ready = (count != DEPTH), combinational from registered count only. There is no same-cycle bypass while full.
- A store presented while st_ready = 0 is not captured. The pipeline holds it.
- Drain (all combinational from head state):
  - mem_we = drain_en && !empty.
  - mem_waddr = entry[head].addr.
  - mem_wdata = entry[head].data.
  - On a rising edge with mem_we = 1, head advances.
  - The memory commits the write on the same edge.
- Count update:
  - +1 on enqueue only.
  - −1 on drain only.
  - Unchanged when both happen in the same cycle, or when neither does.
- Ordering: stores retire strictly in acceptance order. No coalescing. Two stores to the same word both retire.
- Load path (combinational):
  - mem_raddr = ld_addr.
  - Word match is ld_addr[ADDR_W-1:2] == entry.addr[ADDR_W-1:2]; byte offset bits are ignored, matching the memory's word indexing.
  - Compare against every occupied entry (head .. head+count−1, with wrap).
  - If any entry matches, ld_data = data of the youngest matching entry, i.e. closest to tail. Otherwise ld_data = mem_rdata.
  - An entry being drained this cycle still forwards. The memory read shows the pre-write value until the edge, so forwarding is required.
  - A store being enqueued this cycle does not forward to a same-cycle load. The pipeline orders the load after the store.
- Boundary cases:
  - Full with drain_en = 1: st_ready stays 0 this cycle and becomes 1 the next cycle.
  - Empty with drain_en = 1: mem_we = 0 and no pointer movement.
  - Reset asserted mid-drain: mem_we drops immediately. The write at the coincident edge must not occur, since reset dominates.

Test Plan:
- Reset: hold rst_n = 0 with st_valid = 1 and drain_en = 1 → count = 0, empty = 1, st_ready = 1, mem_we = 0, no entries captured.
- Forwarding:
  - Stimulus: drain_en = 0; store 0x010←0xDEADBEEF, then 0x014←0x12345678; mem_rdata held at 0.
  - Load 0x012 → ld_data = 0xDEADBEEF.
  - Load 0x014 → ld_data = 0x12345678.
  - Load 0x018 → ld_data = 0 (from memory).
- Youngest wins: drain_en = 0; store 0x020←0x1, then 0x022←0x2 → load 0x020 returns 0x2, count = 2.
- Full and backpressure:
  - Stimulus: drain_en = 0; store 0x000, 0x004, 0x008, 0x00C with data 1..4; count = 4, st_ready = 0.
  - Fifth store (0x040←5) is held. Raise drain_en → mem_we = 1, mem_waddr = 0x000, mem_wdata = 1.
  - Next cycle: st_ready = 1 and the fifth store is accepted.
  - Memory sees writes 1, 2, 3, 4, 5 in that order.
- Steady state: drain_en = 1 with continuous stores for 10 cycles → count stays 1 after the first cycle, both pointers wrap, memory writes occur in exact acceptance order with no drops.
- Reset mid-operation: 3 entries buffered, drain_en = 1, assert rst_n = 0 mid-cycle → mem_we = 0 immediately, count = 0, the remaining 3 stores never reach memory.
